// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared pointer helpers for the async FIFO write/read controllers.
// Pointers are handled here at a fixed maximum width (ADDRESS_WIDTH up to 16,
// so 17 pointer bits). Callers zero-extend narrower pointers on the way in and
// truncate on the way out. Both Gray conversions give the correct result on
// zero-extended values.
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int MAX_PTR_W = 17;

    typedef logic [MAX_PTR_W-1:0] ptr_t;

    // Pointer width for a given RAM address width: one extra wrap bit.
    function automatic int ptr_w(input int address_width);
        return address_width + 1;
    endfunction

    // Mask with the top two pointer bits set. A full FIFO has a write Gray
    // pointer equal to the read Gray pointer with exactly these bits inverted.
    function automatic ptr_t msb2_mask(input int address_width);
        return ptr_t'(3) << (address_width - 1);
    endfunction

    function automatic ptr_t bin2gray(input ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t gray);
        ptr_t bin;
        logic acc;
        bin = '0;
        acc = 1'b0;
        for (int i = MAX_PTR_W - 1; i >= 0; i--) begin
            acc    = acc ^ gray[i];
            bin[i] = acc;
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// -----------------------------------------------------------------------------
// gray2bin_conv
// Purely combinational Gray-to-binary converter of parametrised width.
// Each binary bit is the XOR of all Gray bits at or above its position
// (XOR prefix from the MSB downward). Shared by the write- and read-side
// pointer controllers.
//
// Ports:
//   gray_i  in   WIDTH  Gray-coded value
//   bin_o   out  WIDTH  binary equivalent
// -----------------------------------------------------------------------------
module gray2bin_conv
    import fifo_pkg::*;
#(
    parameter int WIDTH = MAX_PTR_W
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    logic acc;

    // NOTE: every variable assigned in always_comb gets a value before any
    // conditional or loop logic, so no path can leave it unassigned and infer a latch.
    always_comb begin
        bin_o = '0;
        acc   = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc      = acc ^ gray_i[i];
            bin_o[i] = acc;
        end
    end

endmodule

// File: rtl/wr_ptr_full_ctrl.sv
// -----------------------------------------------------------------------------
// wr_ptr_full_ctrl
// Write-domain pointer and status controller for the async FIFO. It holds the
// binary and Gray write pointers and drives the RAM write address. It produces
// FULL, the write-side fill level, a programmable ALMOST_FULL flag and a sticky
// OVERFLOW error. All write-side flags are pessimistic because the read pointer
// arrives late through a synchroniser.
//
// Ports:
//   CLK          in   1      write-domain clock
//   RST          in   1      synchronous, active-high reset
//   W_inc        in   1      write request from client
//   Wq2_Rptr     in   AW+1   Gray read pointer synchronised into CLK domain
//   AFULL_LVL    in   AW+1   almost-full threshold in words
//   CLR_OVF      in   1      clears OVERFLOW
//   W_en         out  1      write accepted this cycle (W_inc & !FULL)
//   W_addr       out  AW     RAM write address (low bits of binary pointer)
//   W_ptr        out  AW+1   registered Gray write pointer
//   FULL         out  1      registered full flag
//   ALMOST_FULL  out  1      registered, level >= AFULL_LVL
//   W_level      out  AW+1   registered fill level, 0..DEPTH
//   OVERFLOW     out  1      sticky, set by a write attempt while FULL
// -----------------------------------------------------------------------------
module wr_ptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDRESS_WIDTH   = 4,
    parameter bit LEVEL_RST_AFULL = 1'b0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     W_inc,
    input  logic [ADDRESS_WIDTH:0]   Wq2_Rptr,
    input  logic [ADDRESS_WIDTH:0]   AFULL_LVL,
    input  logic                     CLR_OVF,
    output logic                     W_en,
    output logic [ADDRESS_WIDTH-1:0] W_addr,
    output logic [ADDRESS_WIDTH:0]   W_ptr,
    output logic                     FULL,
    output logic                     ALMOST_FULL,
    output logic [ADDRESS_WIDTH:0]   W_level,
    output logic                     OVERFLOW
);

    localparam int               PTR_W     = ptr_w(ADDRESS_WIDTH);
    localparam logic [PTR_W-1:0] MSB2_MASK = PTR_W'(msb2_mask(ADDRESS_WIDTH));

    logic [PTR_W-1:0] bin_q,   bin_d;
    logic [PTR_W-1:0] gray_q,  gray_d;
    logic [PTR_W-1:0] level_q, level_d;
    logic             full_q,  full_d;
    logic             afull_q, afull_d;
    logic             ovf_q,   ovf_d;
    logic [PTR_W-1:0] rbin;

    // Acceptance uses the registered FULL, so a read-pointer advance seen in a
    // full cycle only unblocks writes from the following cycle.
    assign W_en = W_inc & ~full_q;

    gray2bin_conv #(
        .WIDTH (PTR_W)
    ) u_rptr_g2b (
        .gray_i (Wq2_Rptr),
        .bin_o  (rbin)
    );

    always_comb begin
        bin_d   = bin_q + PTR_W'(W_en);
        gray_d  = PTR_W'(bin2gray(ptr_t'(bin_d)));
        // Modulo subtraction against a lagging read pointer can only
        // over-report the fill level, never under-report it.
        level_d = bin_d - rbin;
        full_d  = (gray_d == (Wq2_Rptr ^ MSB2_MASK));
        afull_d = (level_d >= AFULL_LVL);
        // Set has priority over clear so a rejected write is never lost.
        ovf_d   = (W_inc & full_q) | (ovf_q & ~CLR_OVF);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of the order in which processes run.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bin_q   <= '0;
            gray_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            afull_q <= LEVEL_RST_AFULL;
            ovf_q   <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            level_q <= level_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
        end
    end

    assign W_addr      = bin_q[ADDRESS_WIDTH-1:0];
    assign W_ptr       = gray_q;
    assign FULL        = full_q;
    assign ALMOST_FULL = afull_q;
    assign W_level     = level_q;
    assign OVERFLOW    = ovf_q;

endmodule

// File: tb/tb_wr_ptr_full_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wr_ptr_full_ctrl
// Scoreboard bench for wr_ptr_full_ctrl. The stimulus process pushes the
// expected DUT state, tagged with the cycle in which it must be observed. A
// separate monitor pops entries on the falling edge and compares them.
// dut0: ADDRESS_WIDTH=4, LEVEL_RST_AFULL=0.  dut1: ADDRESS_WIDTH=1, LEVEL_RST_AFULL=1.
// -----------------------------------------------------------------------------
module tb_wr_ptr_full_ctrl;

    localparam logic [7:0] M_WEN   = 8'h01;
    localparam logic [7:0] M_ADDR  = 8'h02;
    localparam logic [7:0] M_PTR   = 8'h04;
    localparam logic [7:0] M_FULL  = 8'h08;
    localparam logic [7:0] M_AF    = 8'h10;
    localparam logic [7:0] M_LVL   = 8'h20;
    localparam logic [7:0] M_OVF   = 8'h40;
    localparam logic [7:0] M_ONE   = 8'h80;
    localparam logic [7:0] M_STATE = M_ADDR | M_PTR | M_FULL | M_AF | M_LVL | M_OVF;

    typedef struct {
        int          tgt;
        int          dut;
        string       name;
        logic [7:0]  mask;
        logic        wen;
        logic [16:0] addr;
        logic [16:0] ptr;
        logic [16:0] lvl;
        logic        full;
        logic        af;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t sb[$];

    // dut0 signals
    logic       rst0, inc0, clr0;
    logic [4:0] rptr0, lvl0;
    logic       wen0, full0, af0, ovf0;
    logic [3:0] addr0;
    logic [4:0] ptr0, level0;

    // dut1 signals
    logic       rst1, inc1, clr1;
    logic [1:0] rptr1, lvl1;
    logic       wen1, full1, af1, ovf1;
    logic [0:0] addr1;
    logic [1:0] ptr1, level1;

    wr_ptr_full_ctrl #(.ADDRESS_WIDTH(4), .LEVEL_RST_AFULL(1'b0)) dut0 (
        .CLK(clk), .RST(rst0), .W_inc(inc0), .Wq2_Rptr(rptr0), .AFULL_LVL(lvl0),
        .CLR_OVF(clr0), .W_en(wen0), .W_addr(addr0), .W_ptr(ptr0), .FULL(full0),
        .ALMOST_FULL(af0), .W_level(level0), .OVERFLOW(ovf0)
    );

    wr_ptr_full_ctrl #(.ADDRESS_WIDTH(1), .LEVEL_RST_AFULL(1'b1)) dut1 (
        .CLK(clk), .RST(rst1), .W_inc(inc1), .Wq2_Rptr(rptr1), .AFULL_LVL(lvl1),
        .CLR_OVF(clr1), .W_en(wen1), .W_addr(addr1), .W_ptr(ptr1), .FULL(full1),
        .ALMOST_FULL(af1), .W_level(level1), .OVERFLOW(ovf1)
    );

    // Gray code of b modulo 2**w.
    function automatic logic [16:0] gr(input int b, input int w);
        logic [16:0] v;
        v = 17'(b) & ((17'(1) << w) - 17'(1));
        return v ^ (v >> 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // off=0: observe in the current cycle; off=1: observe after the next edge.
    task automatic push(input int off, input int d, input string nm, input logic [7:0] m,
                        input logic wen, input int addr, input logic [16:0] ptr, input int lvl,
                        input logic full, input logic af, input logic ovf);
        exp_t e;
        e.tgt  = cyc + off;
        e.dut  = d;
        e.name = nm;
        e.mask = m;
        e.wen  = wen;
        e.addr = 17'(addr);
        e.ptr  = ptr;
        e.lvl  = 17'(lvl);
        e.full = full;
        e.af   = af;
        e.ovf  = ovf;
        sb.push_back(e);
    endtask

    task automatic cmp(input string nm, input string fld, input logic [16:0] act, input logic [16:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h (cycle %0d)", nm, fld, act, exp, cyc);
        end
    endtask

    // Monitor
    exp_t        e_m;
    logic [4:0]  prev_ptr0 = '0;
    logic        a_wen, a_full, a_af, a_ovf;
    logic [16:0] a_addr, a_ptr, a_lvl;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].tgt <= cyc) begin
            e_m = sb.pop_front();
            if (e_m.tgt < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: entry for cycle %0d not serviced (now %0d)", e_m.name, e_m.tgt, cyc);
            end else begin
                if (e_m.dut == 0) begin
                    a_wen = wen0; a_addr = 17'(addr0); a_ptr = 17'(ptr0); a_lvl = 17'(level0);
                    a_full = full0; a_af = af0; a_ovf = ovf0;
                end else begin
                    a_wen = wen1; a_addr = 17'(addr1); a_ptr = 17'(ptr1); a_lvl = 17'(level1);
                    a_full = full1; a_af = af1; a_ovf = ovf1;
                end
                if ((e_m.mask & M_WEN)  != 0) cmp(e_m.name, "W_en",        17'(a_wen),  17'(e_m.wen));
                if ((e_m.mask & M_ADDR) != 0) cmp(e_m.name, "W_addr",      a_addr,      e_m.addr);
                if ((e_m.mask & M_PTR)  != 0) cmp(e_m.name, "W_ptr",       a_ptr,       e_m.ptr);
                if ((e_m.mask & M_FULL) != 0) cmp(e_m.name, "FULL",        17'(a_full), 17'(e_m.full));
                if ((e_m.mask & M_AF)   != 0) cmp(e_m.name, "ALMOST_FULL", 17'(a_af),   17'(e_m.af));
                if ((e_m.mask & M_LVL)  != 0) cmp(e_m.name, "W_level",     a_lvl,       e_m.lvl);
                if ((e_m.mask & M_OVF)  != 0) cmp(e_m.name, "OVERFLOW",    17'(a_ovf),  17'(e_m.ovf));
                if ((e_m.mask & M_ONE)  != 0)
                    cmp(e_m.name, "W_ptr_bits_changed", 17'($countones(ptr0 ^ prev_ptr0)), 17'(1));
            end
        end
        prev_ptr0 = ptr0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        rst0 = 1'b1; inc0 = 1'b0; clr0 = 1'b0; rptr0 = '0; lvl0 = 5'd14;
        rst1 = 1'b1; inc1 = 1'b0; clr1 = 1'b0; rptr1 = '0; lvl1 = 2'd2;

        // Reset state of dut0
        push(1, 0, "reset0", M_STATE, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst0 = 1'b0;

        // 1. Fill 16 words, almost-full at 14
        for (int k = 1; k <= 16; k++) begin
            inc0 = 1'b1;
            push(0, 0, $sformatf("fill%0d", k), M_WEN, 1, 0, 0, 0, 0, 0, 0);
            push(1, 0, $sformatf("fill%0d", k), M_STATE, 0, k % 16, gr(k, 5), k,
                 (k == 16), (k >= 14), 0);
            tick();
        end

        // 2. Overflow: 3 blocked writes, clear, then set-wins-over-clear
        for (int k = 1; k <= 3; k++) begin
            inc0 = 1'b1;
            push(0, 0, $sformatf("ovf_wr%0d", k), M_WEN, 0, 0, 0, 0, 0, 0, 0);
            push(1, 0, $sformatf("ovf_wr%0d", k), M_STATE, 0, 0, 17'b11000, 16, 1, 1, 1);
            tick();
        end
        inc0 = 1'b0; clr0 = 1'b1;
        push(1, 0, "ovf_clr", M_STATE, 0, 0, 17'b11000, 16, 1, 1, 0);
        tick();
        inc0 = 1'b1; clr0 = 1'b1;
        push(0, 0, "ovf_setclr", M_WEN, 0, 0, 0, 0, 0, 0, 0);
        push(1, 0, "ovf_setclr", M_STATE, 0, 0, 17'b11000, 16, 1, 1, 1);
        tick();
        inc0 = 1'b0; clr0 = 1'b0;

        // Almost-full threshold boundaries at level 16
        lvl0 = 5'd16;
        push(1, 0, "afull_eq_depth", M_AF, 0, 0, 0, 0, 0, 1, 0);
        tick();
        lvl0 = 5'd17;
        push(1, 0, "afull_gt_depth", M_AF, 0, 0, 0, 0, 0, 0, 0);
        tick();
        lvl0 = 5'd0;
        push(1, 0, "afull_zero", M_AF, 0, 0, 0, 0, 0, 1, 0);
        tick();
        lvl0 = 5'd14;

        // 3. Drain one word, then refill
        rptr0 = 5'b00001;
        push(1, 0, "drain", M_STATE, 0, 0, 17'b11000, 15, 0, 1, 1);
        tick();
        inc0 = 1'b1;
        push(0, 0, "refill", M_WEN, 1, 0, 0, 0, 0, 0, 0);
        push(1, 0, "refill", M_STATE, 0, 1, gr(17, 5), 16, 1, 1, 1);
        tick();
        inc0 = 1'b0;

        // 4. Wrap: 40 writes, read side one completed write behind
        rst0 = 1'b1; rptr0 = '0;
        push(1, 0, "reset_wrap", M_STATE, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst0 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            inc0  = 1'b1;
            rptr0 = 5'(gr((k == 0) ? 0 : k - 1, 5));
            push(0, 0, $sformatf("wrap%0d", k), M_WEN, 1, 0, 0, 0, 0, 0, 0);
            push(1, 0, $sformatf("wrap%0d", k), M_STATE | M_ONE, 0, (k + 1) % 16, gr(k + 1, 5),
                 (k == 0) ? 1 : 2, 0, 0, 0);
            tick();
        end
        inc0 = 1'b0;

        // 6. Reset mid-operation with 9 words written
        rst0 = 1'b1;
        push(1, 0, "reset_pre9", M_STATE, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst0 = 1'b0; rptr0 = '0;
        for (int k = 1; k <= 9; k++) begin
            inc0 = 1'b1;
            push(1, 0, $sformatf("wr9_%0d", k), M_STATE, 0, k, gr(k, 5), k, 0, 0, 0);
            tick();
        end
        rst0 = 1'b1; inc0 = 1'b1;
        push(1, 0, "reset_mid", M_STATE, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst0 = 1'b0; inc0 = 1'b0;
        push(1, 0, "reset_hold", M_STATE, 0, 0, 0, 0, 0, 0, 0);
        tick();
        inc0 = 1'b1;
        push(1, 0, "post_reset_wr", M_STATE, 0, 1, gr(1, 5), 1, 0, 0, 0);
        tick();
        inc0 = 1'b0;

        // 5. Small depth on dut1 (ADDRESS_WIDTH=1)
        push(1, 1, "aw1_reset", M_STATE, 0, 0, 0, 0, 0, 1, 0);
        tick();
        rst1 = 1'b0;
        inc1 = 1'b1;
        push(0, 1, "aw1_wr1", M_WEN, 1, 0, 0, 0, 0, 0, 0);
        push(1, 1, "aw1_wr1", M_STATE, 0, 1, gr(1, 2), 1, 0, 0, 0);
        tick();
        push(0, 1, "aw1_wr2", M_WEN, 1, 0, 0, 0, 0, 0, 0);
        push(1, 1, "aw1_wr2", M_STATE, 0, 0, 17'b11, 2, 1, 1, 0);
        tick();
        push(0, 1, "aw1_wr3", M_WEN, 0, 0, 0, 0, 0, 0, 0);
        push(1, 1, "aw1_wr3", M_STATE, 0, 0, 17'b11, 2, 1, 1, 1);
        tick();
        inc1 = 1'b0;
        rptr1 = 2'b01;
        push(1, 1, "aw1_drain", M_STATE, 0, 0, 17'b11, 1, 0, 0, 1);
        tick();

        // Let the monitor drain the scoreboard
        repeat (3) tick();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
